// File: rtl/led_seq_ctrl.sv
// Switch-code sequencer for the LED state machine: debounced manual pass-through,
// or a timed five-step auto walk launched by a debounced start button.
module led_seq_ctrl #(
    parameter int DB_CYCLES   = 100_000,
    parameter int STEP_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode,
    input  logic       start,
    input  logic       loop,
    input  logic [2:0] sw_in,
    output logic [2:0] sw_out,
    output logic       busy,
    output logic [2:0] step,
    output logic       done
);

    localparam int DBW = $clog2(DB_CYCLES);
    localparam int TMW = $clog2(STEP_CYCLES);
    localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_CYCLES - 1);
    localparam logic [DBW-1:0] DB_ONE   = DBW'(1);
    localparam logic [TMW-1:0] TMR_LAST = TMW'(STEP_CYCLES - 1);
    localparam logic [TMW-1:0] TMR_ONE  = TMW'(1);

    typedef enum logic [1:0] {MAN, WAIT, RUN} state_t;

    function automatic logic [2:0] step_code(input logic [2:0] s);
        case (s)
            3'd1:    step_code = 3'b001;
            3'd2:    step_code = 3'b011;
            3'd3:    step_code = 3'b110;
            3'd4:    step_code = 3'b011;
            3'd5:    step_code = 3'b111;
            default: step_code = 3'b000;
        endcase
    endfunction

    // Bit 3 is start, bits 2:0 are the board switches.
    logic [3:0] raw_in;
    logic [3:0] sync1, sync2, deb;
    logic       mode_s1, mode_s2;
    logic       start_q;
    logic       start_evt;

    assign raw_in = {start, sw_in};

    // NOTE: sequential state always uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, independent of block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1   <= '0;
            sync2   <= '0;
            mode_s1 <= 1'b0;
            mode_s2 <= 1'b0;
            start_q <= 1'b0;
        end else begin
            sync1   <= raw_in;
            sync2   <= sync1;
            mode_s1 <= mode;
            mode_s2 <= mode_s1;
            start_q <= deb[3];
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_db
        logic           deb_bit;
        logic [DBW-1:0] cnt;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                deb_bit <= 1'b0;
                cnt     <= '0;
            end else if (sync2[i] == deb_bit) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                deb_bit <= sync2[i];
                cnt     <= '0;
            end else begin
                cnt <= cnt + DB_ONE;
            end
        end

        assign deb[i] = deb_bit;
    end

    assign start_evt = deb[3] & ~start_q;

    state_t         state_q, state_d;
    logic [2:0]     step_q, step_d;
    logic [2:0]     sw_out_q, sw_out_d;
    logic [TMW-1:0] timer_q, timer_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= MAN;
            step_q   <= 3'd0;
            sw_out_q <= 3'b000;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            sw_out_q <= sw_out_d;
            timer_q  <= timer_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        sw_out_d = sw_out_q;
        timer_d  = timer_q;
        done     = 1'b0;
        case (state_q)
            MAN: begin
                step_d  = 3'd0;
                timer_d = '0;
                if (mode_s2) begin
                    state_d  = WAIT;
                    sw_out_d = 3'b000;
                end else begin
                    sw_out_d = deb[2:0];
                end
            end
            WAIT: begin
                step_d   = 3'd0;
                timer_d  = '0;
                sw_out_d = 3'b000;
                if (!mode_s2) begin
                    state_d  = MAN;
                    sw_out_d = deb[2:0];
                end else if (start_evt) begin
                    state_d  = RUN;
                    step_d   = 3'd1;
                    sw_out_d = step_code(3'd1);
                end
            end
            RUN: begin
                // Dropping mode aborts even on the terminal-count cycle.
                if (!mode_s2) begin
                    state_d  = MAN;
                    step_d   = 3'd0;
                    timer_d  = '0;
                    sw_out_d = deb[2:0];
                end else if (timer_q == TMR_LAST) begin
                    timer_d = '0;
                    if (step_q == 3'd5) begin
                        done = 1'b1;
                        if (loop) begin
                            step_d   = 3'd1;
                            sw_out_d = step_code(3'd1);
                        end else begin
                            state_d  = WAIT;
                            step_d   = 3'd0;
                            sw_out_d = 3'b000;
                        end
                    end else begin
                        step_d   = step_q + 3'd1;
                        sw_out_d = step_code(step_q + 3'd1);
                    end
                end else begin
                    timer_d = timer_q + TMR_ONE;
                end
            end
            default: state_d = MAN;
        endcase
    end

    assign sw_out = sw_out_q;
    assign step   = step_q;
    assign busy   = (state_q == RUN);

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl with DB_CYCLES=4 and STEP_CYCLES=8; expected
// values are hand-computed edge counts from the sequencer's timing rules.
module tb_led_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode, start, loop;
    logic [2:0] sw_in;
    logic [2:0] sw_out;
    logic       busy;
    logic [2:0] step;
    logic       done;

    int n_cmp = 0;
    int n_err = 0;

    logic [2:0] code_tab [5] = '{3'b001, 3'b011, 3'b110, 3'b011, 3'b111};

    led_seq_ctrl #(.DB_CYCLES(4), .STEP_CYCLES(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .mode   (mode),
        .start  (start),
        .loop   (loop),
        .sw_in  (sw_in),
        .sw_out (sw_out),
        .busy   (busy),
        .step   (step),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Walks one full 40-cycle pass starting just after the RUN-entry edge.
    // start is released at cycle 0; optional re-press, release and loop clear.
    task automatic walk(input int press_at, input int release_at, input int loop_off_at);
        for (int i = 0; i < 40; i++) begin
            chk("walk_sw", sw_out, code_tab[i/8]);
            chk("walk_step", step, i/8 + 1);
            chk("walk_busy", busy, 1);
            chk("walk_done", done, i == 39);
            if (i == 0) start = 1'b0;
            if (i == press_at) start = 1'b1;
            if (i == release_at) start = 1'b0;
            if (i == loop_off_at) loop = 1'b0;
            tick(1);
        end
    endtask

    initial begin
        rst   = 1'b0;
        mode  = 1'b0;
        start = 1'b0;
        loop  = 1'b0;
        sw_in = 3'b111;

        // Reset holds every output low regardless of inputs.
        tick(3);
        chk("rst_sw", sw_out, 3'b000);
        chk("rst_busy", busy, 0);
        chk("rst_step", step, 0);
        chk("rst_done", done, 0);

        rst = 1'b1;
        tick(6);
        chk("man_edge6", sw_out, 3'b000);
        tick(1);
        chk("man_edge7", sw_out, 3'b111);

        sw_in = 3'b000;
        tick(7);
        chk("man_clear", sw_out, 3'b000);

        // Three-cycle glitch must not propagate.
        sw_in = 3'b011;
        tick(3);
        sw_in = 3'b000;
        tick(10);
        chk("glitch", sw_out, 3'b000);

        sw_in = 3'b011;
        tick(6);
        chk("hold_edge6", sw_out, 3'b000);
        tick(1);
        chk("hold_edge7", sw_out, 3'b011);

        // Manual -> wait, then single non-looping run.
        mode = 1'b1;
        tick(2);
        chk("to_wait_man", sw_out, 3'b011);
        tick(1);
        chk("wait_sw", sw_out, 3'b000);
        chk("wait_busy", busy, 0);
        start = 1'b1;
        tick(6);
        chk("start_edge6_busy", busy, 0);
        chk("start_edge6_sw", sw_out, 3'b000);
        tick(1);
        walk(-1, -1, -1);
        chk("single_end_sw", sw_out, 3'b000);
        chk("single_end_busy", busy, 0);
        chk("single_end_step", step, 0);
        chk("single_end_done", done, 0);

        // Looping run: two passes, loop cleared mid second pass.
        loop  = 1'b1;
        start = 1'b1;
        tick(7);
        walk(-1, -1, -1);
        walk(-1, -1, 10);
        chk("loop_end_busy", busy, 0);
        chk("loop_end_sw", sw_out, 3'b000);

        // Restart guard: re-press during step 2 changes nothing.
        start = 1'b1;
        tick(7);
        walk(8, 20, -1);
        chk("guard_end_busy", busy, 0);
        tick(10);
        chk("guard_no_memory", busy, 0);
        chk("guard_idle_sw", sw_out, 3'b000);

        // Abort: drop mode during step 3.
        start = 1'b1;
        tick(7);
        for (int i = 0; i < 20; i++) begin
            chk("abort_sw", sw_out, code_tab[i/8]);
            chk("abort_step", step, i/8 + 1);
            chk("abort_done", done, 0);
            if (i == 0) start = 1'b0;
            if (i == 17) mode = 1'b0;
            tick(1);
        end
        chk("abort_busy", busy, 0);
        chk("abort_step0", step, 0);
        chk("abort_done0", done, 0);
        chk("abort_sw_man", sw_out, 3'b011);
        sw_in = 3'b101;
        tick(6);
        chk("abort_follow6", sw_out, 3'b011);
        tick(1);
        chk("abort_follow7", sw_out, 3'b101);

        // Reset mid-run clears outputs immediately.
        mode = 1'b1;
        tick(3);
        start = 1'b1;
        tick(7);
        start = 1'b0;
        tick(3);
        chk("midrun_busy_pre", busy, 1);
        rst = 1'b0;
        #2;
        chk("midrun_busy", busy, 0);
        chk("midrun_step", step, 0);
        chk("midrun_sw", sw_out, 3'b000);
        rst = 1'b1;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
